fp_result_packer: RTL
=====================

Name: fp_result_packer

Overview:
- Output end of the FP add/sub datapath: takes unpacked result fields (sign, 8-bit exponent biased 127, 23-bit mantissa, status flags) and packs them into an IEEE-754 word.
- Single mode: direct field packing. Half mode: rebias exponent, round mantissa to 10 bits, handle overflow and flush-to-zero.
- 2-stage valid/ready pipeline with sticky status flags and a transfer counter, read by the FPU control logic.

Parameters:
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input fields valid.
- in_ready  output  1  packer can accept input this cycle.
- mode_fp  input  1  0 = half, 1 = single.
- round_mode  input  1  0 = round-to-nearest-even, 1 = truncate (toward zero).
- in_sign  input  1  result sign.
- in_exp  input  8  exponent, bias 127 in both modes.
- in_mant  input  23  fraction without implicit bit.
- in_overflow  input  1  upstream overflow flag.
- in_underflow  input  1  upstream underflow flag.
- in_inexact  input  1  upstream inexact flag.
- out_valid  output  1  out_word valid.
- out_ready  input  1  consumer accepts out_word.
- out_word  output  32  packed result; half mode uses [15:0], [31:16] = 0.
- out_flags  output  3  {overflow, underflow, inexact} for out_word.
- flag_clear  input  1  synchronous clear of the sticky status.
- status_flags  output  3  sticky OR of out_flags over completed transfers.
- xfer_count  output  CNT_W  completed output transfers, wraps.

Behaviour:
- Reset: all outputs 0; in_ready = 1 while both stages are empty; pipeline emptied. Reset mid-operation discards in-flight entries with no output.
- Input handshake: accept when in_valid & in_ready.
- Output handshake: transfer when out_valid & out_ready.
- Stage 1 registers the inputs and computes the packing. Stage 2 is the output register.
- Latency: accept in cycle N gives out_valid in cycle N+2. Throughput: 1 per cycle when out_ready is held high.
- Stall: while out_valid & !out_ready, out_word and out_flags stay stable. Stage 1 may still fill.
- in_ready = !s1_valid | (s2 advances this cycle) | !s2_valid. Maximum of 2 entries in flight; no entry is lost or duplicated.
- Single mode:
  - out_word = {sign, exp, mant}.
  - out_flags = {in_overflow, in_underflow, in_inexact}.
- Half mode:
  - he = in_exp - 112. Kept mantissa m10 = in_mant[22:13]. guard = in_mant[12]. sticky = |in_mant[11:0].
  - in_exp == 0 and in_mant == 0: output signed zero {sign,15'b0}; flags pass through.
  - in_exp <= 112, nonzero: flush to {sign,15'b0}; underflow = 1; inexact = 1.
  - Normal range (113..142): round up when round_mode = 0 and guard & (sticky | m10[0]).
  - Rounding carry out of m10 sets m10 = 0 and he = he + 1.
  - inexact = in_inexact | guard | sticky.
  - Overflow when in_exp >= 143 or post-round he == 31. Output {sign,5'h1F,10'h0} when round_mode = 0, {sign,5'h1E,10'h3FF} when round_mode = 1. Flags overflow = 1, inexact = 1.
  - Otherwise output {sign, he[4:0], m10}; underflow = in_underflow; overflow = in_overflow.
- Status:
  - On each output transfer: status_flags |= out_flags and xfer_count += 1, wrapping from all-ones to 0.
  - flag_clear without a transfer: status_flags = 0.
  - flag_clear in the same cycle as a transfer: status_flags = that transfer's out_flags.
  - flag_clear does not affect xfer_count.

Test Plan:
- Single mode, sign 0, exp 0x7F, mant 0 -> out_word 0x3F800000 at N+2, out_flags 000, xfer_count 1.
- Half mode, RNE, exp 0x7F:
  - mant 0x000000 -> 0x00003C00, flags 000.
  - mant 0x001000 -> 0x3C00, inexact.
  - mant 0x003000 -> 0x3C02, inexact.
- Half mode, exp 0x8E, mant 0x7FFFFF:
  - RNE -> 0x7C00, flags 101.
  - Truncate -> 0x7BFF, flags 001.
- Half mode, sign 1, exp 0x70, mant 0x400000 -> 0x8000, flags 011. Then flag_clear in the same cycle as the next zero-flag transfer -> status_flags 000.
- Backpressure:
  - out_ready low, send 3 back-to-back inputs -> in_ready deasserts after 2 accepts; out_word stays stable.
  - Then out_ready high -> 3 results in order on consecutive cycles.
- Reset asserted with 2 entries in flight -> out_valid 0 immediately; status_flags and xfer_count 0; no output after release.

Source files
------------

// File: rtl/fp_result_packer.sv
// rtl/fp_result_packer.sv - packs unpacked FP add/sub result fields into single or half IEEE-754 words
// Two-stage valid/ready pipeline with sticky status flags and a completed-transfer counter.
module fp_result_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode_fp,
  input  logic             round_mode,
  input  logic             in_sign,
  input  logic [7:0]       in_exp,
  input  logic [22:0]      in_mant,
  input  logic             in_overflow,
  input  logic             in_underflow,
  input  logic             in_inexact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [2:0]       out_flags,
  input  logic             flag_clear,
  output logic [2:0]       status_flags,
  output logic [CNT_W-1:0] xfer_count
);

  logic             r_s1_valid;
  logic             r_s1_mode;
  logic             r_s1_rm;
  logic             r_s1_sign;
  logic [7:0]       r_s1_exp;
  logic [22:0]      r_s1_mant;
  logic [2:0]       r_s1_flags;
  logic             r_s2_valid;
  logic [31:0]      r_s2_word;
  logic [2:0]       r_s2_flags;
  logic [2:0]       r_status;
  logic [CNT_W-1:0] r_count;

  logic             w_xfer;
  logic             w_s2_free;
  logic             w_s1_load;
  logic             w_guard;
  logic             w_sticky;
  logic             w_round_up;
  logic [10:0]      w_m11;
  logic [4:0]       w_he;
  logic [4:0]       w_he_r;
  logic             w_ovf;
  logic [31:0]      w_word;
  logic [2:0]       w_flags;

  assign w_xfer    = r_s2_valid & out_ready;
  assign w_s2_free = !r_s2_valid | out_ready;
  assign in_ready  = !r_s1_valid | w_s2_free;
  assign w_s1_load = in_valid & in_ready;

  assign out_valid    = r_s2_valid;
  assign out_word     = r_s2_word;
  assign out_flags    = r_s2_flags;
  assign status_flags = r_status;
  assign xfer_count   = r_count;

  // Half exponent only needs 5 bits: 112 is 16 mod 32, and the normal range never wraps.
  always_comb begin
    w_guard    = r_s1_mant[12];
    w_sticky   = |r_s1_mant[11:0];
    w_round_up = !r_s1_rm & w_guard & (w_sticky | r_s1_mant[13]);
    w_m11      = {1'b0, r_s1_mant[22:13]} + {10'd0, w_round_up};
    w_he       = r_s1_exp[4:0] - 5'd16;
    w_he_r     = w_he + {4'd0, w_m11[10]};
    w_ovf      = (r_s1_exp >= 8'd143) | (w_he_r == 5'h1F);
    w_word     = 32'h0;
    w_flags    = r_s1_flags;
    if (r_s1_mode) begin
      w_word = {r_s1_sign, r_s1_exp, r_s1_mant};
    end else if ((r_s1_exp == 8'd0) && (r_s1_mant == 23'd0)) begin
      w_word = {16'h0, r_s1_sign, 15'h0};
    end else if (r_s1_exp <= 8'd112) begin
      w_word     = {16'h0, r_s1_sign, 15'h0};
      w_flags[1] = 1'b1;
      w_flags[0] = 1'b1;
    end else if (w_ovf) begin
      w_word     = {16'h0, r_s1_sign, (r_s1_rm ? 15'h7BFF : 15'h7C00)};
      w_flags[2] = 1'b1;
      w_flags[0] = 1'b1;
    end else begin
      w_word     = {16'h0, r_s1_sign, w_he_r, w_m11[9:0]};
      w_flags[0] = r_s1_flags[0] | w_guard | w_sticky;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_rm    <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= 8'd0;
      r_s1_mant  <= 23'd0;
      r_s1_flags <= 3'd0;
      r_s2_valid <= 1'b0;
      r_s2_word  <= 32'h0;
      r_s2_flags <= 3'd0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
        r_s1_mode  <= mode_fp;
        r_s1_rm    <= round_mode;
        r_s1_sign  <= in_sign;
        r_s1_exp   <= in_exp;
        r_s1_mant  <= in_mant;
        r_s1_flags <= {in_overflow, in_underflow, in_inexact};
      end else if (w_s2_free) begin
        r_s1_valid <= 1'b0;
      end
      // Output register only moves when empty or draining, which keeps it stable under stall.
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_word  <= w_word;
          r_s2_flags <= w_flags;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= 3'd0;
      r_count  <= '0;
    end else begin
      if (w_xfer) begin
        r_status <= flag_clear ? r_s2_flags : (r_status | r_s2_flags);
        r_count  <= r_count + 1'b1;
      end else if (flag_clear) begin
        r_status <= 3'd0;
      end
    end
  end

endmodule
